// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multiword adder: FSM state
// encoding, counter-width and operand-width helpers.
package madd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width for a given slice count; a single-slice build still keeps one bit.
  function automatic int madd_cnt_w(int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Full operand width from slice width and slice count.
  function automatic int madd_width(int n, int k);
    return n * k;
  endfunction

  // Counter width of the default configuration (K = 4).
  localparam int MADD_CNT_W = madd_cnt_w(4);

endpackage

// File: rtl/multiword_adder_seq_if.sv
// Operand/result handshake bundle for multiword_adder_seq.
// The sub line exists only when MULTIWORD_ADDER_SEQ_SUB_EN is defined.
interface multiword_adder_seq_if #(
  parameter int N = 64,
  parameter int K = 4
) ();
  import madd_pkg::*;

  localparam int W = madd_width(N, K);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/multiword_adder_seq_slice.sv
// prefix_slice_adder: N-bit combinational Kogge-Stone adder with carry in/out.
// The carry-in is folded into the bit-0 generate term so the prefix tree
// yields every bit carry, including the one out of the top bit.
module prefix_slice_adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int LV = $clog2(N);

  logic [N-1:0] p_bit;
  logic [N-1:0] g_cur;
  logic [N-1:0] p_cur;
  logic [N-1:0] g_nxt;
  logic [N-1:0] p_nxt;

  // Prefix tree: level lv combines each bit with the group 2**lv below it.
  always_comb begin
    p_bit    = a_i ^ b_i;
    g_cur    = a_i & b_i;
    g_cur[0] = g_cur[0] | (p_bit[0] & cin_i);
    p_cur    = p_bit;
    g_nxt    = g_cur;
    p_nxt    = p_cur;
    for (int lv = 0; lv < LV; lv++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = (1 << lv); i < N; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << lv)]);
        p_nxt[i] = p_cur[i] & p_cur[i - (1 << lv)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    sum_o  = p_bit ^ {g_cur[N-2:0], cin_i};
    cout_o = g_cur[N-1];
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: adds two N*K-bit operands one N-bit slice per cycle
// through a single prefix_slice_adder, carrying between slices in a register.
// Optional feature: define MULTIWORD_ADDER_SEQ_SUB_EN to add a sub input
// (A-B via inverted B and carry-in of 1; cout=1 then means no borrow).
module multiword_adder_seq
  import madd_pkg::*;
#(
  parameter int N = 64,
  parameter int K = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiword_adder_seq_if.slave bus
);

  localparam int W  = madd_width(N, K);
  localparam int CW = madd_cnt_w(K);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [N-1:0]    slice_s;
  logic            slice_c;
  logic            sub_w;
  logic [W+N-1:0]  sum_cat;

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif

  prefix_slice_adder #(.N(N)) u_slice (
    .a_i    (a_q[N-1:0]),
    .b_i    (b_q[N-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_s),
    .cout_o (slice_c)
  );

  // New slice result enters the sum register from the top.
  assign sum_cat = {slice_s, sum_q};

  // Next-state and datapath steering; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = sub_w ? ~bus.b : bus.b;
          carry_d = sub_w;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        sum_d   = sum_cat[W+N-1:N];
        carry_d = slice_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          cout_d  = slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
